// File: rtl/cp_pkg.sv
// Shared core types for register addressing and datapath width.
package cp_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [4:0]      reg_addr_t;
    typedef logic [XLEN-1:0] xlen_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/cp_wb_scoreboard.sv
// Pending-write scoreboard: one busy flag per architectural register.
module cp_wb_scoreboard
    import cp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_rd_addr_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_addr_i,
    output logic [31:0] busy_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d, set_vec, clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid_i && reg_addr_t'(issue_rd_addr_i) != REG_ZERO)
            set_vec[issue_rd_addr_i] = 1'b1;
        if (wb_we_i)
            clr_vec[wb_addr_i] = 1'b1;
        // A new issue to a register being written back leaves it pending.
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

    // NOTE: the flag array is small and must read as all-clear after reset, so every bit is reset.
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/cp_wb_arbiter.sv
// Two-source (ALU/LSU) register-file writeback arbiter with 1-cycle write latency.
// Optional pending-write scoreboard enabled by defining CP_WB_SCOREBOARD_EN.
module cp_wb_arbiter
    import cp_pkg::*;
#(
    parameter logic RR_EN           = 1'b1,
    parameter logic FIXED_LSU_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [4:0]  alu_rd_addr_i,
    input  logic [31:0] alu_rd_data_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_rd_addr_i,
    input  logic [31:0] lsu_rd_data_i,
    output logic        rd_we_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_rd_addr_i,
    output logic [31:0] busy_o
);

    logic      tie;
    logic      grant_lsu;
    logic      accept;
    logic      lsu_ptr_q, lsu_ptr_d;
    logic      rd_we_q, rd_we_d;
    reg_addr_t rd_addr_q, rd_addr_d;
    xlen_t     rd_data_q, rd_data_d;

    assign tie = alu_valid_i && lsu_valid_i;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant_lsu = 1'b0;
        lsu_ptr_d = lsu_ptr_q;
        if (tie) begin
            grant_lsu = RR_EN ? lsu_ptr_q : FIXED_LSU_FIRST;
            if (!rst) lsu_ptr_d = ~grant_lsu;
        end else begin
            grant_lsu = lsu_valid_i;
        end
    end

    // Ready is gated by reset so nothing pending at reset is ever accepted.
    assign alu_ready_o = !rst && alu_valid_i && !grant_lsu;
    assign lsu_ready_o = !rst && lsu_valid_i &&  grant_lsu;
    assign accept      = alu_ready_o || lsu_ready_o;

    always_comb begin
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (accept) begin
            rd_addr_d = grant_lsu ? lsu_rd_addr_i : alu_rd_addr_i;
            rd_data_d = grant_lsu ? lsu_rd_data_i : alu_rd_data_i;
        end
        rd_we_d = accept && (rd_addr_d != REG_ZERO);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_ptr_q <= FIXED_LSU_FIRST;
            rd_we_q   <= 1'b0;
            rd_addr_q <= REG_ZERO;
            rd_data_q <= '0;
        end else begin
            lsu_ptr_q <= lsu_ptr_d;
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_we_o   = rd_we_q;
    assign rd_addr_o = rd_addr_q;
    assign rd_data_o = rd_data_q;

`ifdef CP_WB_SCOREBOARD_EN
    cp_wb_scoreboard u_scoreboard (
        .clk             (clk),
        .rst             (rst),
        .issue_valid_i   (issue_valid_i),
        .issue_rd_addr_i (issue_rd_addr_i),
        .wb_we_i         (rd_we_q),
        .wb_addr_i       (rd_addr_q),
        .busy_o          (busy_o)
    );
`else
    logic unused_issue;
    assign unused_issue = ^{issue_valid_i, issue_rd_addr_i};
    assign busy_o       = '0;
`endif

endmodule

// File: tb/tb_cp_wb_arbiter.sv
// Directed bench: round-robin DUT plus a fixed-priority DUT sharing the same stimulus.
`timescale 1ns/1ps
module tb_cp_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid, issue_valid;
    logic [4:0]  alu_rd, lsu_rd, issue_rd;
    logic [31:0] alu_data, lsu_data;

    logic        alu_ready, lsu_ready, rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data, busy;
    logic        fx_alu_ready, fx_lsu_ready, fx_rd_we;
    logic [4:0]  fx_rd_addr;
    logic [31:0] fx_rd_data, fx_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cp_wb_arbiter #(.RR_EN(1'b1), .FIXED_LSU_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready),
        .alu_rd_addr_i(alu_rd), .alu_rd_data_i(alu_data),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready),
        .lsu_rd_addr_i(lsu_rd), .lsu_rd_data_i(lsu_data),
        .rd_we_o(rd_we), .rd_addr_o(rd_addr), .rd_data_o(rd_data),
        .issue_valid_i(issue_valid), .issue_rd_addr_i(issue_rd),
        .busy_o(busy)
    );

    cp_wb_arbiter #(.RR_EN(1'b0), .FIXED_LSU_FIRST(1'b1)) dut_fx (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid), .alu_ready_o(fx_alu_ready),
        .alu_rd_addr_i(alu_rd), .alu_rd_data_i(alu_data),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(fx_lsu_ready),
        .lsu_rd_addr_i(lsu_rd), .lsu_rd_data_i(lsu_data),
        .rd_we_o(fx_rd_we), .rd_addr_o(fx_rd_addr), .rd_data_o(fx_rd_data),
        .issue_valid_i(issue_valid), .issue_rd_addr_i(issue_rd),
        .busy_o(fx_busy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one cycle; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef CP_WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        tick();
        tick();

        // Reset state, and ready held low under reset even with a request.
        check("rst_we",   {31'b0, rd_we}, 32'd0);
        check("rst_addr", {27'b0, rd_addr}, 32'd0);
        check("rst_data", rd_data, 32'd0);
        check("rst_busy", busy, 32'd0);
        alu_valid = 1'b1; lsu_valid = 1'b1; #1;
        check("rst_ready", {30'b0, alu_ready, lsu_ready}, 32'd0);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        rst = 1'b0;
        tick();

        // ALU alone.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234; #1;
        check("alu_only_ready", {30'b0, alu_ready, lsu_ready}, 32'b10);
        tick();
        check("alu_only_we",   {31'b0, rd_we}, 32'd1);
        check("alu_only_addr", {27'b0, rd_addr}, 32'd5);
        check("alu_only_data", rd_data, 32'h1234);
        alu_valid = 1'b0;
        tick();
        check("idle_we",   {31'b0, rd_we}, 32'd0);
        check("idle_addr", {27'b0, rd_addr}, 32'd5);
        check("idle_data", rd_data, 32'h1234);

        // Four-cycle tie: RR alternates LSU, ALU, LSU, ALU; fixed always LSU.
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hAAAA_0001;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hBBBB_0002;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready", {30'b0, alu_ready, lsu_ready}, (i % 2 == 0) ? 32'b01 : 32'b10);
            check("fx_ready", {30'b0, fx_alu_ready, fx_lsu_ready}, 32'b01);
            tick();
            check("rr_we",   {31'b0, rd_we}, 32'd1);
            check("rr_addr", {27'b0, rd_addr}, (i % 2 == 0) ? 32'd2 : 32'd1);
            check("fx_addr", {27'b0, fx_rd_addr}, 32'd2);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
        check("tie_end_we", {31'b0, rd_we}, 32'd0);

        // LSU write to x0 is accepted but not written.
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF; #1;
        check("x0_ready", {30'b0, alu_ready, lsu_ready}, 32'b01);
        tick();
        check("x0_we", {31'b0, rd_we}, 32'd0);
        lsu_valid = 1'b0;

        // Scoreboard set, set-wins-over-clear, then clear.
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        check("sb_set", busy, SB ? 32'h80 : 32'h0);
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        tick();
        check("sb_wb_we",   {31'b0, rd_we}, 32'd1);
        check("sb_wb_addr", {27'b0, rd_addr}, 32'd7);
        alu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        check("sb_set_wins", busy, SB ? 32'h80 : 32'h0);
        issue_valid = 1'b0; alu_valid = 1'b1;
        tick();
        alu_valid = 1'b0;
        tick();
        check("sb_clear", busy, 32'h0);
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        check("sb_x0", busy, 32'h0);
        issue_valid = 1'b0;

        // One tie moves the pointer to ALU, then reset arrives with a request pending.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
        issue_valid = 1'b1; issue_rd = 5'd9; #1;
        check("pre_rst_tie", {30'b0, alu_ready, lsu_ready}, 32'b01);
        tick();
        check("pre_rst_busy", busy, SB ? 32'h200 : 32'h0);
        rst = 1'b1; #1;
        check("mid_rst_ready", {30'b0, alu_ready, lsu_ready}, 32'd0);
        tick();
        check("mid_rst_we",   {31'b0, rd_we}, 32'd0);
        check("mid_rst_busy", busy, 32'h0);
        rst = 1'b0; issue_valid = 1'b0; #1;
        check("post_rst_tie", {30'b0, alu_ready, lsu_ready}, 32'b01);
        tick();
        check("post_rst_addr", {27'b0, rd_addr}, 32'd4);
        check("post_rst_data", rd_data, 32'h44);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp_wb_arbiter.md
CP_WB_ARBITER -- requirements
Module: cp_wb_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority per FIXED_LSU_FIRST.
REQ-002 SHALL have parameter FIXED_LSU_FIRST, default 1, 1 = LSU wins fixed-priority ties and the first round-robin tie after reset; 0 = ALU.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port alu_valid_i  input  1  ALU writeback request.
REQ-006 SHALL have port alu_ready_o  output  1  ALU request accepted this cycle.
REQ-007 SHALL have port alu_rd_addr_i  input  5  ALU destination register.
REQ-008 SHALL have port alu_rd_data_i  input  32  ALU result.
REQ-009 SHALL have port lsu_valid_i  input  1  load writeback request.
REQ-010 SHALL have port lsu_ready_o  output  1  LSU request accepted this cycle.
REQ-011 SHALL have port lsu_rd_addr_i  input  5  load destination register.
REQ-012 SHALL have port lsu_rd_data_i  input  32  load data.
REQ-013 SHALL have port rd_we_o  output  1  register-file write enable.
REQ-014 SHALL have port rd_addr_o  output  5  register-file write address.
REQ-015 SHALL have port rd_data_o  output  32  register-file write data.
REQ-016 SHALL have port issue_valid_i  input  1  instruction with a destination register issued.
REQ-017 SHALL have port issue_rd_addr_i  input  5  destination of the issued instruction.
REQ-018 SHALL have port busy_o  output  32  per-register pending-write flags; bit n = x[n].

Function
REQ-019 SHALL accept a request when valid_i and ready_o are both high in the same cycle; ready_o SHALL be high only for the granted source and SHALL depend combinationally on the valid inputs and the grant pointer.
REQ-020 SHALL grant the only valid source when exactly one source is valid; ready_o of an idle source SHALL be low.
REQ-021 SHALL, when both sources are valid and RR_EN=1, grant the source not granted on the most recent two-way tie; the pointer SHALL update only on a two-way tie.
REQ-022 SHALL, when both sources are valid and RR_EN=0, always grant the source selected by FIXED_LSU_FIRST.
REQ-023 SHALL register the accepted address and data: an acceptance in cycle N drives rd_we_o=1 with that address and data in cycle N+1, for a fixed latency of 1.
REQ-024 SHALL accept writebacks to x0 but hold rd_we_o=0 in the following cycle.
REQ-025 SHALL drive rd_we_o=0 in any cycle following one with no acceptance; rd_addr_o and rd_data_o SHALL then hold their previous values.
REQ-026 SHALL sustain one acceptance per cycle with no bubbles; a source with valid_i low SHALL have no effect on arbitration.

Reset
REQ-027 SHALL, while rst=1, drive rd_we_o=0, rd_addr_o=0, rd_data_o=0, and busy_o=0, and reset the round-robin pointer so the first tie goes to the FIXED_LSU_FIRST source.
REQ-028 SHALL drive both ready_o outputs low while rst=1; a request pending when reset asserts mid-stream SHALL be dropped and never written.

Configuration
REQ-029 SHALL compile the scoreboard only when the macro CP_WB_SCOREBOARD_EN is defined.
REQ-030 SHALL, with CP_WB_SCOREBOARD_EN defined, set busy[n] the cycle after issue_valid_i=1 with issue_rd_addr_i=n, where n is not 0.
REQ-031 SHALL, with CP_WB_SCOREBOARD_EN defined, clear busy[n] in the same edge on which rd_we_o=1 and rd_addr_o=n.
REQ-032 SHALL, with CP_WB_SCOREBOARD_EN defined and a set and clear for the same register coinciding, apply the set so busy[n]=1; busy[0] SHALL always be 0.
REQ-033 SHALL, without CP_WB_SCOREBOARD_EN, tie busy_o to 0 and ignore issue_valid_i and issue_rd_addr_i; arbitration SHALL be identical in both builds.

Structure
REQ-034 SHALL take from shared package cp_pkg the typedefs reg_addr_t (5 bits), xlen_t (32 bits), and the constant REG_ZERO=5'd0.
REQ-035 SHALL place the scoreboard in the sub-module cp_wb_scoreboard, instantiated only under CP_WB_SCOREBOARD_EN.

Verification
REQ-036 SHALL cover: ALU alone, valid with rd=5 and data=0x1234 -> alu_ready_o=1; next cycle rd_we_o=1, rd_addr_o=5, rd_data_o=0x1234.
REQ-037 SHALL cover: both sources valid for 4 cycles with RR_EN=1 -> grants LSU, ALU, LSU, ALU; rd_we_o high on 4 consecutive cycles.
REQ-038 SHALL cover: both sources valid with RR_EN=0 and FIXED_LSU_FIRST=1 -> LSU granted every cycle, alu_ready_o held 0.
REQ-039 SHALL cover: LSU writes rd=0 with data=0xFFFF -> lsu_ready_o=1; next cycle rd_we_o=0.
REQ-040 SHALL cover, with the macro defined: issue rd=7 -> busy_o[7]=1; a later issue of rd=7 coinciding with the writeback of rd=7 -> busy_o[7] stays 1.
REQ-041 SHALL cover: rst asserted during a cycle with an acceptance -> next cycle rd_we_o=0, busy_o=0, and the first tie afterwards goes to LSU.
